// File: rtl/chunked_serial_adder_if.sv
// Handshake and data bundle for chunked_serial_adder.
// Optional feature macro: SUBTRACT_EN adds the 'sub' operand-side signal.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds its data stable while valid
// is high and ready is low. The consumer may change ready at any time.
interface chunked_serial_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef SUBTRACT_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    // Adder side: takes operands, produces results.
    modport slave (
        input  in_valid, a, b, carry_in,
`ifdef SUBTRACT_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );

    // Producer/consumer side that drives the adder.
    modport master (
        output in_valid, a, b, carry_in,
`ifdef SUBTRACT_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit slice per clock with a registered
// carry between slices. Reports carry-out and signed overflow.
// Optional feature macro: SUBTRACT_EN (adds bus.sub; sub=1 computes a - b - carry_in).
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    chunked_serial_adder_if.slave   bus,
    output logic                    busy,
    output logic [1:0]              dbg_state
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("chunked_serial_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;     // already inverted for subtraction
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [CHUNK-1:0]  a_sl, b_sl, s_sl;
    logic              c_sl;
    logic              b_inv;

    // Subtraction folds into the add path: invert b and the carry at acceptance.
`ifdef SUBTRACT_EN
    assign b_inv = bus.sub;
`else
    assign b_inv = 1'b0;
`endif

    // Next-state, slice arithmetic and operand capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        a_sl = a_q[int'(idx_q)*CHUNK +: CHUNK];
        b_sl = b_q[int'(idx_q)*CHUNK +: CHUNK];
        {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{b_inv}};
                    carry_d = bus.carry_in ^ b_inv;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*CHUNK +: CHUNK] = s_sl;
                carry_d = c_sl;
                if (idx_q == LAST_IDX) begin
                    // Carry into the MSB is recovered from the MSB sum bit.
                    cout_d  = c_sl;
                    ovf_d   = c_sl ^ (a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                // New operands are only taken in IDLE, never in the same edge.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: a 16/4 instance and an 8/8 instance.
module tb_chunked_serial_adder;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    chunked_serial_adder_if #(.WIDTH(16)) bus16 ();
    chunked_serial_adder_if #(.WIDTH(8))  bus8 ();
    logic       busy16, busy8;
    logic [1:0] st16, st8;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus16),
        .busy      (busy16),
        .dbg_state (st16)
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus8),
        .busy      (busy8),
        .dbg_state (st8)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [17:0] exp_q[$];   // {carry_out, overflow, sum}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic add16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec, input logic eo);
        int          lat;
        logic [17:0] exp;
        exp_q.push_back({ec, eo, es});
        check({tag, " in_ready"}, 32'(bus16.in_ready), 32'(1));
        bus16.a = a; bus16.b = b; bus16.carry_in = cin; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.a = 16'($urandom_range(0, 65535));
        bus16.b = 16'($urandom_range(0, 65535));
        bus16.carry_in = 1'($urandom_range(0, 1));
        lat = 0;
        while (bus16.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(4));
        exp = exp_q.pop_front();
        check({tag, " sum"},       32'(bus16.sum),       32'(exp[15:0]));
        check({tag, " carry_out"}, 32'(bus16.carry_out), 32'(exp[17]));
        check({tag, " overflow"},  32'(bus16.overflow),  32'(exp[16]));
    endtask

    task automatic drain16(input string tag);
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        check({tag, " drained out_valid"}, 32'(bus16.out_valid), 32'(0));
        check({tag, " drained in_ready"},  32'(bus16.in_ready),  32'(1));
    endtask

    task automatic add8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic ec, input logic eo);
        int          lat;
        logic [17:0] exp;
        exp_q.push_back({ec, eo, 8'h00, es});
        bus8.a = a; bus8.b = b; bus8.carry_in = cin; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(1));
        exp = exp_q.pop_front();
        check({tag, " sum"},       32'(bus8.sum),       32'(exp[7:0]));
        check({tag, " carry_out"}, 32'(bus8.carry_out), 32'(exp[17]));
        check({tag, " overflow"},  32'(bus8.overflow),  32'(exp[16]));
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check({tag, " drained"}, 32'(bus8.in_ready), 32'(1));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.carry_in = 1'b0; bus16.out_ready = 1'b0;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.carry_in  = 1'b0; bus8.out_ready  = 1'b0;
`ifdef SUBTRACT_EN
        bus16.sub = 1'b0;
        bus8.sub  = 1'b0;
`endif
        #2;
        // Reset values
        check("reset sum",       32'(bus16.sum),       32'(0));
        check("reset carry_out", 32'(bus16.carry_out), 32'(0));
        check("reset overflow",  32'(bus16.overflow),  32'(0));
        check("reset out_valid", 32'(bus16.out_valid), 32'(0));
        check("reset busy",      32'(busy16),          32'(0));
        check("reset in_ready",  32'(bus16.in_ready),  32'(1));
        check("reset state",     32'(st16),            32'(0));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1. basic add
        add16("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        check("busy in DONE", 32'(busy16), 32'(1));
        drain16("add 1234+4321");
        // 2. full carry ripple
        add16("add ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain16("add ffff+0001");
        // 3. signed overflow
        add16("add 7fff+0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        drain16("add 7fff+0001");
        add16("add 8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        drain16("add 8000+8000");
        // carry_in path
        add16("add 00ff+0000+cin", 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
        drain16("add 00ff+cin");

        // 4. backpressure in DONE with in_valid driven
        add16("bp 1111+2222", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        bus16.in_valid = 1'b1; bus16.a = 16'hAAAA; bus16.b = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp out_valid held", 32'(bus16.out_valid), 32'(1));
            check("bp in_ready low",   32'(bus16.in_ready),  32'(0));
            check("bp sum held",       32'(bus16.sum),       32'(16'h3333));
        end
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
        check("bp back to IDLE", 32'(st16),            32'(0));
        check("bp not accepted", 32'(busy16),          32'(0));
        check("bp in_ready",     32'(bus16.in_ready),  32'(1));
        check("bp sum kept",     32'(bus16.sum),       32'(16'h3333));
        @(posedge clk); #1;
        check("bp still IDLE",   32'(st16),            32'(0));

        // 5. reset mid-operation
        bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.carry_in = 1'b0; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid-run busy", 32'(busy16), 32'(1));
        rst_n = 1'b0;
        #1;
        check("abort sum",       32'(bus16.sum),       32'(0));
        check("abort carry_out", 32'(bus16.carry_out), 32'(0));
        check("abort overflow",  32'(bus16.overflow),  32'(0));
        check("abort out_valid", 32'(bus16.out_valid), 32'(0));
        check("abort busy",      32'(busy16),          32'(0));
        check("abort in_ready",  32'(bus16.in_ready),  32'(1));
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("after reset IDLE", 32'(st16), 32'(0));
        add16("add 0003+0004", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
        drain16("add 0003+0004");

`ifdef SUBTRACT_EN
        // 6. subtraction
        bus16.sub = 1'b1;
        add16("sub 0005-0007", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        drain16("sub 0005-0007");
        add16("sub 8000-0001", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        drain16("sub 8000-0001");
        bus16.sub = 1'b0;
        add16("sub0 1234+4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        drain16("sub0 1234+4321");
`endif

        // 8-bit single-chunk instance
        add8("w8 12+43", 8'h12, 8'h43, 1'b0, 8'h55, 1'b0, 1'b0);
        add8("w8 ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        add8("w8 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        add8("w8 80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        check("scoreboard empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
